// File: rtl/mips_pkg.sv
// Shared fetch-stage types: fetch FSM states, bubble word, opcode constants.
package mips_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; bubble beats hold, hold (load=0) beats load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter word_t NOP = mips_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr,
  input  word_t pc4,
  output word_t id_instr,
  output word_t id_pc4,
  output logic  id_valid
);
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      id_instr <= NOP;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr <= instr;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, +4 adder, BOOT/RUN/HALT fetch FSM, IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  input  logic        restart,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op
);
  fetch_state_t state;
  word_t        pc;
  word_t        pc_next4;
  logic         run;
  logic         load;
  logic         bubble;

  assign pc_next4  = pc + 32'd4;  // wraps mod 2^32 by width
  assign run       = (state == RUN);
  assign imem_addr = pc;
  assign imem_en   = rst_n && run;

  // Redirect outranks stall; halted cycles drain IF/ID with bubbles.
  assign bubble = (run && branch_taken) || (state == HALT);
  assign load   = run && !branch_taken && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= BOOT;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (branch_taken)
            pc <= branch_target & ~32'd3;
          else if (!stall)
            pc <= pc_next4;
          if (halt)
            state <= HALT;
        end
        HALT: begin
          if (restart) begin
            pc    <= RESET_PC;
            state <= BOOT;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bubble   (bubble),
    .instr    (imem_rdata),
    .pc4      (pc_next4),
    .id_instr (if_id_instr),
    .id_pc4   (if_id_pc4),
    .id_valid (if_id_valid)
  );

  assign op = if_id_instr[31:26];
endmodule

// File: tb/tb_if_stage.sv
// Fetch-stage bench: directed scenarios plus random traffic against a fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .restart(restart),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .op(op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata = mem(imem_addr);

  // Behavioural model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      model_ok = 1'b1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (branch_taken) begin
        m_pc = {branch_target[31:2], 2'b00};
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
      if (halt) m_mode = 2;
    end else begin
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      if (restart) begin m_pc = 32'd0; m_mode = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_addr",  imem_addr, m_pc);
      chk("m_en",    {31'd0, imem_en}, {31'd0, m_mode == 1});
      chk("m_instr", if_id_instr, m_instr);
      chk("m_pc4",   if_id_pc4, m_pc4);
      chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("m_op",    {26'd0, op}, {26'd0, m_instr[31:26]});
    end
  end

  task automatic step(input logic rn, input logic s, input logic b,
                      input logic [31:0] t, input logic h, input logic r);
    @(negedge clk);
    #1;
    rst_n = rn; stall = s; branch_taken = b; branch_target = t; halt = h; restart = r;
    @(posedge clk);
    #2;
  endtask

  task automatic run1();
    step(1, 0, 0, 32'd0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 32'd0, 0, 0);
    step(0, 1, 1, 32'h0000_0100, 1, 0);
    chk("rst_en",    {31'd0, imem_en}, 32'd0);
    chk("rst_pc",    imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_op",    {26'd0, op}, 32'd0);

    run1();                                    // BOOT edge -> RUN
    chk("boot_pc", imem_addr, 32'd0);
    chk("run_en",  {31'd0, imem_en}, 32'd1);
    run1();
    chk("first_instr", if_id_instr, 32'h8C01_0004);
    chk("first_op",    {26'd0, op}, 32'h23);
    chk("first_pc4",   if_id_pc4, 32'd4);
    chk("first_valid", {31'd0, if_id_valid}, 32'd1);
    run1();
    chk("pc8", imem_addr, 32'd8);

    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'd0, 0, 0);
    chk("stall_pc",  imem_addr, 32'd8);
    chk("stall_pc4", if_id_pc4, 32'd8);
    run1();
    chk("resume_instr", if_id_instr, mem(32'd8));
    chk("resume_pc4",   if_id_pc4, 32'd12);
    run1(); run1();
    chk("pc20", imem_addr, 32'd20);

    step(1, 0, 0, 32'd0, 1, 0);                // halt at PC=20
    chk("halt_pc4",   if_id_pc4, 32'd24);
    chk("halt_instr", if_id_instr, mem(32'd20));
    for (int i = 0; i < 5; i++) begin
      step(1, i[0], 1, 32'h0000_0200, 1, 0);
      chk("halted_en",    {31'd0, imem_en}, 32'd0);
      chk("halted_valid", {31'd0, if_id_valid}, 32'd0);
    end
    step(1, 0, 0, 32'd0, 1, 1);                // restart beats halt
    chk("restart_pc", imem_addr, 32'd0);
    chk("restart_en", {31'd0, imem_en}, 32'd0);
    run1(); run1(); run1();
    chk("rerun_pc", imem_addr, 32'd8);
    step(0, 1, 1, 32'h0000_0300, 0, 0);        // reset mid-redirect
    chk("rst2_pc",    imem_addr, 32'd0);
    chk("rst2_instr", if_id_instr, 32'd0);
    chk("rst2_en",    {31'd0, imem_en}, 32'd0);
    run1(); run1(); run1();

    step(1, 1, 1, 32'h0000_0042, 0, 0);        // redirect wins over stall
    chk("br_pc",    imem_addr, 32'h0000_0040);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_op",    {26'd0, op}, 32'd0);
    step(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("br_top", imem_addr, 32'hFFFF_FFFC);
    run1();
    chk("wrap_pc",  imem_addr, 32'd0);
    chk("wrap_pc4", if_id_pc4, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) >= 2), ($urandom_range(3) == 0),
           ($urandom_range(9) == 0), $urandom,
           ($urandom_range(19) == 0), ($urandom_range(2) == 0));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset and on restart from HALT.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  hazard hold from decode; freezes PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request (Branch & Zero) resolved downstream.
REQ-007 branch_target  input  32  redirect PC; valid when branch_taken=1.
REQ-008 halt  input  1  stop fetching after the current cycle.
REQ-009 restart  input  1  leave HALT and resume fetching at RESET_PC.
REQ-010 imem_addr  output  32  instruction memory word address; equals PC.
REQ-011 imem_en  output  1  instruction memory read enable.
REQ-012 imem_rdata  input  32  instruction word, combinational read of imem_addr in the same cycle.
REQ-013 if_id_instr  output  32  registered instruction passed to decode.
REQ-014 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-015 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.
REQ-016 op  output  6  if_id_instr[31:26]; feeds the main controller Op input.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and HALT; BOOT is the reset state.
REQ-018 BOOT SHALL last exactly one cycle with imem_en=0 and PC held, then move to RUN.
REQ-019 In RUN, imem_en SHALL be 1, and each non-stalled, non-redirected cycle SHALL load PC<=PC+4, if_id_instr<=imem_rdata, if_id_pc4<=PC+4 and if_id_valid<=1.
REQ-020 PC+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-021 branch_taken=1 in RUN SHALL load PC<=branch_target and put a bubble in IF/ID: NOP_INSTR, valid=0, pc4=0.
REQ-022 branch_taken SHALL take priority over stall; a redirect in a stalled cycle is not lost.
REQ-023 stall=1 without branch_taken SHALL hold PC, if_id_instr, if_id_pc4 and if_id_valid unchanged.
REQ-024 halt=1 in RUN SHALL move to HALT next cycle; the word fetched in that cycle SHALL still be registered, unless stall or branch_taken also applies, in which case REQ-021 or REQ-023 governs IF/ID.
REQ-025 In HALT, imem_en SHALL be 0, PC SHALL hold, and IF/ID SHALL be loaded with a bubble every cycle.
REQ-026 restart=1 in HALT SHALL load PC<=RESET_PC and move to BOOT; restart SHALL be ignored outside HALT.
REQ-027 If halt and restart are both 1 in HALT, restart SHALL win.
REQ-028 branch_taken, stall and halt SHALL be ignored in BOOT and HALT.
REQ-029 branch_target bits [1:0] SHALL be forced to 0 when loaded into PC.
REQ-030 op SHALL be a pure slice of the registered if_id_instr, with no extra latency.
REQ-031 Fetch-to-decode latency SHALL be one cycle: the word read at PC appears on if_id_instr on the next rising edge.

Reset
REQ-032 When rst_n=0 at a rising edge, the block SHALL set PC=RESET_PC, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
REQ-033 While in reset, imem_en SHALL be 0 and op SHALL be 6'b000000.
REQ-034 Reset SHALL override all other inputs, including reset asserted mid-redirect, mid-stall or in HALT.
REQ-035 The block SHALL have no asynchronous reset path.

Structure
REQ-036 The shared package mips_pkg SHALL hold: the fetch state enum (BOOT/RUN/HALT), the NOP_INSTR constant, the opcode constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100) and a 32-bit word typedef.
REQ-037 The IF/ID pipeline register SHALL be a sub-module if_id_reg with inputs load, bubble, instr and pc4, and with the priority rule bubble > hold > load.
REQ-038 The PC register, adder and FSM SHALL live in if_stage.

Verification
REQ-039 Reset release, imem returns 32'h8C01_0004 at PC 0: one BOOT cycle with imem_en=0, then if_id_instr=32'h8C01_0004, op=6'b100011, pc4=4, valid=1.
REQ-040 Straight-line fetch of 4 words: PC goes 0,4,8,12,16; if_id_pc4 follows one cycle later; valid stays 1.
REQ-041 stall=1 for 3 cycles at PC=8: PC and IF/ID stay frozen; after release, fetch resumes at 8 with no lost or duplicated word.
REQ-042 branch_taken=1, branch_target=32'h0000_0042, stall=1 in the same cycle: next PC=32'h0000_0040, IF/ID holds a bubble (valid=0, op=0).
REQ-043 PC=32'hFFFF_FFFC: next PC=0 and if_id_pc4=0.
REQ-044 halt at PC=20, then restart after 5 cycles, then rst_n=0 during the following RUN: bubbles and imem_en=0 while halted; BOOT, then PC=0 after restart; reset values appear on the reset edge.
